// File: rtl/pim_indirect_args_regfile.sv
// Argument / LUT-x register file for PIM indirect addressing with fill/ready/lock handshake.
// Optional dropped-write counter enabled by defining PIM_IAR_DROP_CNT_EN.
`timescale 1ns/1ps

module pim_indirect_args_regfile #(
  parameter int                   DATA_WIDTH   = 256,
  parameter int                   ARG_WIDTH    = 32,
  parameter int                   NUM_ARGS     = 3,
  parameter int                   NUM_BANKS    = 16,
  parameter logic [31:0]          ARGS_BASE    = 32'h0000_1000,
  parameter logic [31:0]          ARGS_STRIDE  = 32'h0000_1000,
  parameter logic [31:0]          LUT_BASE     = 32'h0000_8000,
  parameter logic [NUM_ARGS-1:0]  ARG_REQ_MASK = {NUM_ARGS{1'b1}}
) (
  input  logic                            clk,
  input  logic                            rst_x,
  input  logic                            i_write_en,
  input  logic [31:0]                     i_addr,
  input  logic [DATA_WIDTH-1:0]           i_write_data,
  input  logic                            i_PIM_dev_working,
  input  logic                            i_HPC_clear,
  input  logic                            i_args_consume,
  output logic [NUM_ARGS*ARG_WIDTH-1:0]   o_args_reg,
  output logic [NUM_ARGS-1:0]             o_args_valid,
  output logic                            o_args_ready,
  output logic                            o_args_locked,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] o_lut_x,
  output logic [NUM_BANKS-1:0]            o_lut_valid,
  output logic [15:0]                     o_wr_drop_cnt
);

  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int LUT_LSB = 5 + BANK_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    READY  = 2'd2,
    LOCKED = 2'd3
  } state_e;

  logic                                  s1Wen_q;
  logic [31:0]                           s1Addr_q;
  logic [DATA_WIDTH-1:0]                 s1Wdata_q;

  logic [NUM_ARGS-1:0][ARG_WIDTH-1:0]    argsReg_q;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  lut_q;
  logic [NUM_BANKS-1:0]                  lutValid_q;

  state_e                                state_q, state_d;
  logic [NUM_ARGS-1:0]                   argsValid_q, argsValid_d;
  logic [NUM_ARGS-1:0]                   argsValidCommit;
  logic                                  argsReady_q, argsLocked_q;

  logic [NUM_ARGS-1:0]                   argHit;
  logic                                  argWrite, argCommit;
  logic                                  lutHit, lutCommit;
  logic [BANK_W-1:0]                     bankSel;
  logic                                  maskDone;

  // S1: one register stage on the host write path; clear flushes it.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      s1Wen_q   <= 1'b0;
      s1Addr_q  <= '0;
      s1Wdata_q <= '0;
    end else if (i_HPC_clear) begin
      s1Wen_q   <= 1'b0;
      s1Addr_q  <= '0;
      s1Wdata_q <= '0;
    end else begin
      s1Wen_q   <= i_write_en;
      s1Addr_q  <= i_addr;
      s1Wdata_q <= i_write_data;
    end
  end

  always_comb begin
    argHit = '0;
    for (int k = 0; k < NUM_ARGS; k++) begin
      if (s1Wen_q && (s1Addr_q == ARGS_BASE + ARGS_STRIDE * 32'(k))) begin
        argHit[k] = 1'b1;
      end
    end
  end

  assign argWrite  = |argHit;
  assign argCommit = argWrite && (state_q != LOCKED);
  assign lutHit    = s1Wen_q && (s1Addr_q[31:LUT_LSB] == LUT_BASE[31:LUT_LSB]);
  assign lutCommit = lutHit && i_PIM_dev_working;
  assign bankSel   = s1Addr_q[5 +: BANK_W];

  // Ready evaluation must see the valid bit landing in this same cycle.
  assign argsValidCommit = argCommit ? (argsValid_q | argHit) : argsValid_q;
  assign maskDone        = ((argsValidCommit & ARG_REQ_MASK) == ARG_REQ_MASK);

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      argsReg_q  <= '0;
      lut_q      <= '0;
      lutValid_q <= '0;
    end else if (i_HPC_clear) begin
      argsReg_q  <= '0;
      lut_q      <= '0;
      lutValid_q <= '0;
    end else begin
      for (int k = 0; k < NUM_ARGS; k++) begin
        if (argCommit && argHit[k]) begin
          argsReg_q[k] <= s1Wdata_q[ARG_WIDTH-1:0];
        end
      end
      if (lutCommit) begin
        lut_q[bankSel]      <= s1Wdata_q;
        lutValid_q[bankSel] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    argsValid_d = argsValidCommit;
    case (state_q)
      IDLE:   if (argCommit) state_d = maskDone ? READY : FILL;
      FILL:   if (maskDone) state_d = READY;
      READY:  if (i_args_consume) state_d = LOCKED;
      LOCKED: begin
        // Device finished: release the set but keep the values for reuse.
        if (!i_PIM_dev_working) begin
          state_d     = IDLE;
          argsValid_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q      <= IDLE;
      argsValid_q  <= '0;
      argsReady_q  <= 1'b0;
      argsLocked_q <= 1'b0;
    end else if (i_HPC_clear) begin
      state_q      <= IDLE;
      argsValid_q  <= '0;
      argsReady_q  <= 1'b0;
      argsLocked_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      argsValid_q  <= argsValid_d;
      argsReady_q  <= (state_d == READY);
      argsLocked_q <= (state_d == LOCKED);
    end
  end

`ifdef PIM_IAR_DROP_CNT_EN
  logic        argDrop, lutDrop;
  logic [15:0] dropCnt_q;

  assign argDrop = argWrite && (state_q == LOCKED);
  assign lutDrop = lutHit && !i_PIM_dev_working;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      dropCnt_q <= 16'h0;
    end else if (i_HPC_clear) begin
      dropCnt_q <= 16'h0;
    end else if ((argDrop || lutDrop) && (dropCnt_q != 16'hFFFF)) begin
      dropCnt_q <= dropCnt_q + 16'h1;
    end
  end

  assign o_wr_drop_cnt = dropCnt_q;
`else
  assign o_wr_drop_cnt = 16'h0;
`endif

  assign o_args_reg    = argsReg_q;
  assign o_args_valid  = argsValid_q;
  assign o_args_ready  = argsReady_q;
  assign o_args_locked = argsLocked_q;
  assign o_lut_x       = lut_q;
  assign o_lut_valid   = lutValid_q;

endmodule

// File: tb/tb_pim_indirect_args_regfile.sv
// Bench for pim_indirect_args_regfile: directed scenarios, randomized traffic against a
// behavioural model, and a small-parameter instance (2 args, 4 banks, mask 2'b10).
`timescale 1ns/1ps

module tb_pim_indirect_args_regfile;

`ifdef PIM_IAR_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int S_IDLE   = 0;
  localparam int S_FILL   = 1;
  localparam int S_READY  = 2;
  localparam int S_LOCKED = 3;

  logic          clk;
  logic          rst_x;
  logic          writeEn;
  logic [31:0]   addr;
  logic [255:0]  writeData;
  logic          devWorking;
  logic          hpcClear;
  logic          argsConsume;
  logic [95:0]   argsReg;
  logic [2:0]    argsValid;
  logic          argsReady;
  logic          argsLocked;
  logic [4095:0] lutX;
  logic [15:0]   lutValid;
  logic [15:0]   dropCnt;

  logic          swWriteEn;
  logic [31:0]   swAddr;
  logic [255:0]  swWriteData;
  logic          swWorking;
  logic [63:0]   swArgsReg;
  logic [1:0]    swArgsValid;
  logic          swArgsReady;
  logic          swArgsLocked;
  logic [1023:0] swLutX;
  logic [3:0]    swLutValid;
  logic [15:0]   swDropCnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: arg set, LUT contents, handshake phase, pending write.
  logic [31:0]  mArgs[3];
  logic [2:0]   mValid;
  logic [255:0] mLut[16];
  logic [15:0]  mLutValid;
  int           mState;
  logic [15:0]  mDrop;
  logic         pWen;
  logic [31:0]  pAddr;
  logic [255:0] pData;

  pim_indirect_args_regfile dut (
    .clk               (clk),
    .rst_x             (rst_x),
    .i_write_en        (writeEn),
    .i_addr            (addr),
    .i_write_data      (writeData),
    .i_PIM_dev_working (devWorking),
    .i_HPC_clear       (hpcClear),
    .i_args_consume    (argsConsume),
    .o_args_reg        (argsReg),
    .o_args_valid      (argsValid),
    .o_args_ready      (argsReady),
    .o_args_locked     (argsLocked),
    .o_lut_x           (lutX),
    .o_lut_valid       (lutValid),
    .o_wr_drop_cnt     (dropCnt)
  );

  pim_indirect_args_regfile #(
    .NUM_ARGS     (2),
    .NUM_BANKS    (4),
    .ARG_REQ_MASK (2'b10)
  ) u_sweep (
    .clk               (clk),
    .rst_x             (rst_x),
    .i_write_en        (swWriteEn),
    .i_addr            (swAddr),
    .i_write_data      (swWriteData),
    .i_PIM_dev_working (swWorking),
    .i_HPC_clear       (1'b0),
    .i_args_consume    (1'b0),
    .o_args_reg        (swArgsReg),
    .o_args_valid      (swArgsValid),
    .o_args_ready      (swArgsReady),
    .o_args_locked     (swArgsLocked),
    .o_lut_x           (swLutX),
    .o_lut_valid       (swLutValid),
    .o_wr_drop_cnt     (swDropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] randWord();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) mArgs[k] = '0;
    for (int b = 0; b < 16; b++) mLut[b] = '0;
    mValid    = '0;
    mLutValid = '0;
    mState    = S_IDLE;
    mDrop     = '0;
    pWen      = 1'b0;
    pAddr     = '0;
    pData     = '0;
  endtask

  task automatic bumpDrop();
    if (mDrop != 16'hFFFF) mDrop = mDrop + 16'h1;
  endtask

  // One clock of the behaviour: the write presented last cycle lands now,
  // judged against this cycle's device-busy, consume and clear inputs.
  task automatic modelStep(input logic wen, input logic [31:0] a, input logic [255:0] d,
                           input logic work, input logic clr, input logic cons);
    bit committed;
    if (clr) begin
      modelReset();
    end else begin
      committed = 1'b0;
      if (pWen) begin
        for (int k = 0; k < 3; k++) begin
          if (pAddr == 32'h1000 * 32'(k + 1)) begin
            if (mState == S_LOCKED) bumpDrop();
            else begin
              mArgs[k]  = pData[31:0];
              mValid[k] = 1'b1;
              committed = 1'b1;
            end
          end
        end
        if (pAddr[31:9] == 23'h40) begin
          if (work) begin
            mLut[pAddr[8:5]]      = pData;
            mLutValid[pAddr[8:5]] = 1'b1;
          end else bumpDrop();
        end
      end
      case (mState)
        S_IDLE:   if (committed) mState = (mValid == 3'b111) ? S_READY : S_FILL;
        S_FILL:   if (mValid == 3'b111) mState = S_READY;
        S_READY:  if (cons) mState = S_LOCKED;
        default:  if (!work) begin mState = S_IDLE; mValid = '0; end
      endcase
      pWen  = wen;
      pAddr = a;
      pData = d;
    end
  endtask

  task automatic checkAll();
    checkOutput("args_valid", 256'(argsValid), 256'(mValid));
    checkOutput("args_ready", 256'(argsReady), 256'(mState == S_READY));
    checkOutput("args_locked", 256'(argsLocked), 256'(mState == S_LOCKED));
    checkOutput("args_reg", 256'(argsReg), 256'({mArgs[2], mArgs[1], mArgs[0]}));
    checkOutput("lut_valid", 256'(lutValid), 256'(mLutValid));
    checkOutput("drop_cnt", 256'(dropCnt), CNT_EN ? 256'(mDrop) : 256'(0));
    for (int b = 0; b < 16; b++) checkOutput("lut_x", lutX[b*256 +: 256], mLut[b]);
  endtask

  // Drive one cycle of inputs, advance past the edge, then compare against the model.
  task automatic applyStimulus(input logic wen, input logic [31:0] a, input logic [255:0] d,
                               input logic work, input logic clr, input logic cons);
    writeEn     = wen;
    addr        = a;
    writeData   = d;
    devWorking  = work;
    hpcClear    = clr;
    argsConsume = cons;
    @(posedge clk);
    modelStep(wen, a, d, work, clr, cons);
    #1;
    checkAll();
  endtask

  initial begin
    logic [255:0] lutWord;
    logic [31:0]  a;
    logic         wen, work, clr, cons;
    int           r;

    rst_x = 1'b0;
    writeEn = 1'b0; addr = '0; writeData = '0;
    devWorking = 1'b0; hpcClear = 1'b0; argsConsume = 1'b0;
    swWriteEn = 1'b0; swAddr = '0; swWriteData = '0; swWorking = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    checkOutput("rst_sweep_ready", 256'(swArgsReady), 256'(0));
    rst_x = 1'b1;

    // Fill the three args back to back; each becomes valid two cycles after its write.
    applyStimulus(1'b1, 32'h1000, 256'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_valid0", 256'(argsValid), 256'(3'b000));
    applyStimulus(1'b1, 32'h2000, 256'd6, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_valid1", 256'(argsValid), 256'(3'b001));
    applyStimulus(1'b1, 32'h3000, 256'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_valid2", 256'(argsValid), 256'(3'b011));
    checkOutput("fill_not_ready", 256'(argsReady), 256'(0));
    applyStimulus(1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_valid3", 256'(argsValid), 256'(3'b111));
    checkOutput("fill_ready", 256'(argsReady), 256'(1));

    // Consume locks the set; a later arg write is dropped.
    applyStimulus(1'b1, 32'h1000, 256'd9, 1'b1, 1'b0, 1'b1);
    checkOutput("lock_locked", 256'(argsLocked), 256'(1));
    applyStimulus(1'b0, 32'h0, 256'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("lock_arg0", 256'(argsReg[31:0]), 256'(5));
    checkOutput("lock_drop", 256'(dropCnt), CNT_EN ? 256'(1) : 256'(0));

    // LUT write to bank 15 while the device is busy.
    lutWord = randWord();
    applyStimulus(1'b1, 32'h0000_81E0, lutWord, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 256'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("lut15_data", lutX[15*256 +: 256], lutWord);
    checkOutput("lut15_valid", 256'(lutValid), 256'(16'h8000));

    // Device idles: set released, values kept.
    applyStimulus(1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("unlock_locked", 256'(argsLocked), 256'(0));
    checkOutput("unlock_valid", 256'(argsValid), 256'(0));
    checkOutput("unlock_args", 256'(argsReg), 256'({32'd7, 32'd6, 32'd5}));

    // LUT write while idle device is dropped.
    applyStimulus(1'b1, 32'h0000_81E0, randWord(), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lutdrop_data", lutX[15*256 +: 256], lutWord);
    checkOutput("lutdrop_cnt", 256'(dropCnt), CNT_EN ? 256'(2) : 256'(0));

    // Clear collides with an arg commit; nothing survives.
    applyStimulus(1'b1, 32'h1000, 256'hAA, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2000, 256'hBB, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_args", 256'(argsReg), 256'(0));
    checkOutput("clr_lut_valid", 256'(lutValid), 256'(0));
    checkOutput("clr_cnt", 256'(dropCnt), 256'(0));
    applyStimulus(1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("clr_after_args", 256'(argsReg), 256'(0));
    checkOutput("clr_after_valid", 256'(argsValid), 256'(0));

    // Asynchronous reset in the middle of a cycle.
    applyStimulus(1'b1, 32'h1000, 256'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2000, 256'h22, 1'b0, 1'b0, 1'b0);
    #2 rst_x = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("arst_args", 256'(argsReg), 256'(0));
    #2 rst_x = 1'b1;

    // Randomized traffic biased toward arg and LUT addresses plus near misses.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: a = 32'h1000 * 32'($urandom_range(1, 3));
        5, 6:          a = 32'h8000 | (32'($urandom_range(0, 15)) << 5) | 32'($urandom_range(0, 31));
        7:             a = ($urandom_range(0, 1) == 0) ? 32'h1004 : 32'h4000;
        8:             a = 32'h8200;
        default:       a = $urandom;
      endcase
      wen  = ($urandom_range(0, 9) < 7);
      work = ($urandom_range(0, 3) != 0);
      cons = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 63) == 0);
      applyStimulus(wen, a, randWord(), work, clr, cons);
    end

    // Small instance: arg1 alone completes its mask, LUT 0x8060 is bank 3.
    applyStimulus(1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 1'b0);
    swWriteEn = 1'b1; swAddr = 32'h2000; swWriteData = 256'h77; swWorking = 1'b0;
    applyStimulus(1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sweep_ready_early", 256'(swArgsReady), 256'(0));
    lutWord = randWord();
    swAddr = 32'h0000_8060; swWriteData = lutWord; swWorking = 1'b1;
    applyStimulus(1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sweep_valid", 256'(swArgsValid), 256'(2'b10));
    checkOutput("sweep_ready", 256'(swArgsReady), 256'(1));
    checkOutput("sweep_arg1", 256'(swArgsReg[63:32]), 256'(32'h77));
    swWriteEn = 1'b0;
    applyStimulus(1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sweep_lut_valid", 256'(swLutValid), 256'(4'b1000));
    checkOutput("sweep_lut3", swLutX[3*256 +: 256], lutWord);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
